// File: rtl/detection_event_logger.sv
// detection_event_logger
// Timestamps each accepted detector pulse against a free-running cycle
// counter and queues the stamps in a first-word-fall-through FIFO that a
// reader drains over valid/ready. Also keeps saturating event and drop
// counters and a sticky overflow flag.
module detection_event_logger #(
    parameter int TS_WIDTH  = 16,
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       clear,
    input  logic                       detect_in,
    input  logic                       evt_ready,
    output logic                       evt_valid,
    output logic [TS_WIDTH-1:0]        evt_timestamp,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [CNT_WIDTH-1:0]       evt_count,
    output logic [CNT_WIDTH-1:0]       dropped_count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [TS_WIDTH-1:0]  TS_ONE   = TS_WIDTH'(1'b1);
    localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1'b1);
    localparam logic [LVL_W-1:0]     LVL_ONE  = LVL_W'(1'b1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    // State registers
    logic [TS_WIDTH-1:0]  r_ts;
    logic [TS_WIDTH-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    logic [CNT_WIDTH-1:0] r_evt_count;
    logic [CNT_WIDTH-1:0] r_drop_count;
    logic                 r_overflow;

    // Next-state and control wires
    logic [TS_WIDTH-1:0]  w_ts_nxt;
    logic [PTR_W-1:0]     w_wr_ptr_nxt;
    logic [PTR_W-1:0]     w_rd_ptr_nxt;
    logic [LVL_W-1:0]     w_level_nxt;
    logic [CNT_WIDTH-1:0] w_evt_count_nxt;
    logic [CNT_WIDTH-1:0] w_drop_count_nxt;
    logic                 w_overflow_nxt;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_event;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_wr_en;

    // Level never exceeds DEPTH (a power of two), so its MSB alone marks full.
    assign w_empty = (r_level == {LVL_W{1'b0}});
    assign w_full  = r_level[LVL_W-1];
    assign w_event = enable & detect_in;
    assign w_pop   = ~w_empty & evt_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push  = w_event & (~w_full | w_pop);
    assign w_drop  = w_event & w_full & ~w_pop;
    assign w_wr_en = ~clear & w_push;

    // Next-state computation for counters, pointers and flags; clear wins.
    always_comb begin
        w_ts_nxt         = r_ts;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_rd_ptr_nxt     = r_rd_ptr;
        w_level_nxt      = r_level;
        w_evt_count_nxt  = r_evt_count;
        w_drop_count_nxt = r_drop_count;
        w_overflow_nxt   = r_overflow;
        if (clear) begin
            w_ts_nxt         = {TS_WIDTH{1'b0}};
            w_wr_ptr_nxt     = {PTR_W{1'b0}};
            w_rd_ptr_nxt     = {PTR_W{1'b0}};
            w_level_nxt      = {LVL_W{1'b0}};
            w_evt_count_nxt  = {CNT_WIDTH{1'b0}};
            w_drop_count_nxt = {CNT_WIDTH{1'b0}};
            w_overflow_nxt   = 1'b0;
        end else begin
            if (enable) begin
                w_ts_nxt = r_ts + TS_ONE;
            end else begin
                w_ts_nxt = r_ts;
            end
            if (w_push) begin
                w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
            end else begin
                w_wr_ptr_nxt = r_wr_ptr;
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
            end else begin
                w_rd_ptr_nxt = r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   w_level_nxt = r_level + LVL_ONE;
                2'b01:   w_level_nxt = r_level - LVL_ONE;
                default: w_level_nxt = r_level;
            endcase
            if (w_event && (r_evt_count != CNT_MAX)) begin
                w_evt_count_nxt = r_evt_count + CNT_ONE;
            end else begin
                w_evt_count_nxt = r_evt_count;
            end
            if (w_drop) begin
                w_overflow_nxt = 1'b1;
                if (r_drop_count != CNT_MAX) begin
                    w_drop_count_nxt = r_drop_count + CNT_ONE;
                end else begin
                    w_drop_count_nxt = r_drop_count;
                end
            end else begin
                w_overflow_nxt   = r_overflow;
                w_drop_count_nxt = r_drop_count;
            end
        end
    end

    // Control-state registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ts         <= {TS_WIDTH{1'b0}};
            r_wr_ptr     <= {PTR_W{1'b0}};
            r_rd_ptr     <= {PTR_W{1'b0}};
            r_level      <= {LVL_W{1'b0}};
            r_evt_count  <= {CNT_WIDTH{1'b0}};
            r_drop_count <= {CNT_WIDTH{1'b0}};
            r_overflow   <= 1'b0;
        end else begin
            r_ts         <= w_ts_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_level      <= w_level_nxt;
            r_evt_count  <= w_evt_count_nxt;
            r_drop_count <= w_drop_count_nxt;
            r_overflow   <= w_overflow_nxt;
        end
    end

    // FIFO storage: captures the pre-increment timestamp at the tail.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {TS_WIDTH{1'b0}};
            end
        end else if (w_wr_en) begin
            r_mem[r_wr_ptr] <= r_ts;
        end
    end

    // Outputs are direct decodes of registers; head reads as zero when empty.
    assign evt_valid     = ~w_empty;
    assign evt_timestamp = w_empty ? {TS_WIDTH{1'b0}} : r_mem[r_rd_ptr];
    assign fifo_level    = r_level;
    assign evt_count     = r_evt_count;
    assign dropped_count = r_drop_count;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_detection_event_logger.sv
// Self-checking bench for detection_event_logger: a table of vectors with
// hand-derived expectations, a timestamp scoreboard checked every cycle,
// and hand-written sequences for the multi-cycle corner cases.
module tb_detection_event_logger;

    localparam int DEPTH = 8;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        clear;
    logic        detect_in;
    logic        evt_ready;

    logic        evt_valid;
    logic [15:0] evt_timestamp;
    logic [3:0]  fifo_level;
    logic [15:0] evt_count;
    logic [15:0] dropped_count;
    logic        overflow;

    logic        evt_valid4;
    logic [3:0]  evt_timestamp4;
    logic [3:0]  fifo_level4;
    logic [15:0] evt_count4;
    logic [15:0] dropped_count4;
    logic        overflow4;

    detection_event_logger #(.TS_WIDTH(16), .DEPTH(DEPTH), .CNT_WIDTH(16)) u_dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .detect_in(detect_in), .evt_ready(evt_ready),
        .evt_valid(evt_valid), .evt_timestamp(evt_timestamp),
        .fifo_level(fifo_level), .evt_count(evt_count),
        .dropped_count(dropped_count), .overflow(overflow)
    );

    detection_event_logger #(.TS_WIDTH(4), .DEPTH(DEPTH), .CNT_WIDTH(16)) u_dut4 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .detect_in(detect_in), .evt_ready(evt_ready),
        .evt_valid(evt_valid4), .evt_timestamp(evt_timestamp4),
        .fifo_level(fifo_level4), .evt_count(evt_count4),
        .dropped_count(dropped_count4), .overflow(overflow4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Scoreboard of expected timestamps plus reference counters.
    logic [15:0] sb [$];
    logic [15:0] m_ts;
    logic [15:0] m_cnt;
    logic [15:0] m_drop;
    logic        m_ov;

    typedef struct {
        logic        en;
        logic        clr;
        logic        det;
        logic        rdy;
        logic        e_valid;
        logic [15:0] e_head;
        logic [3:0]  e_level;
        logic [15:0] e_cnt;
        logic [15:0] e_drop;
        logic        e_ov;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_ts   = 16'd0;
        m_cnt  = 16'd0;
        m_drop = 16'd0;
        m_ov   = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, evt_valid}, 32'd0);
        chk({tag, "_ts"},    {16'd0, evt_timestamp}, 32'd0);
        chk({tag, "_level"}, {28'd0, fifo_level}, 32'd0);
        chk({tag, "_cnt"},   {16'd0, evt_count}, 32'd0);
        chk({tag, "_drop"},  {16'd0, dropped_count}, 32'd0);
        chk({tag, "_ov"},    {31'd0, overflow}, 32'd0);
    endtask

    task automatic check_model();
        logic [15:0] head;
        head = (sb.size() != 0) ? sb[0] : 16'd0;
        chk("sb_valid", {31'd0, evt_valid}, {31'd0, sb.size() != 0});
        chk("sb_head",  {16'd0, evt_timestamp}, {16'd0, head});
        chk("sb_level", {28'd0, fifo_level}, 32'(sb.size()));
        chk("sb_cnt",   {16'd0, evt_count}, {16'd0, m_cnt});
        chk("sb_drop",  {16'd0, dropped_count}, {16'd0, m_drop});
        chk("sb_ov",    {31'd0, overflow}, {31'd0, m_ov});
        chk("sb_head4", {28'd0, evt_timestamp4}, {28'd0, head[3:0]});
        chk("sb_level4", {28'd0, fifo_level4}, 32'(sb.size()));
    endtask

    // Drive one cycle, advance the reference on the edge, then compare.
    task automatic step(input logic en, input logic clr, input logic det, input logic rdy);
        logic [15:0] popped;
        enable    = en;
        clear     = clr;
        detect_in = det;
        evt_ready = rdy;
        @(posedge clock);
        if (clr) begin
            model_reset();
        end else begin
            if (rdy && sb.size() != 0) popped = sb.pop_front();
            if (en && det) begin
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (sb.size() < DEPTH) begin
                    sb.push_back(m_ts);
                end else begin
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                    m_ov = 1'b1;
                end
            end
            if (en) m_ts = m_ts + 16'd1;
        end
        #1;
        check_model();
    endtask

    function automatic vec_t mk(input logic en, input logic clr, input logic det, input logic rdy,
                                input logic ev, input logic [15:0] eh, input logic [3:0] el,
                                input logic [15:0] ec, input logic [15:0] ed, input logic eo);
        vec_t v;
        v.en = en; v.clr = clr; v.det = det; v.rdy = rdy;
        v.e_valid = ev; v.e_head = eh; v.e_level = el;
        v.e_cnt = ec; v.e_drop = ed; v.e_ov = eo;
        return v;
    endfunction

    initial begin
        reset = 1'b0; enable = 1'b0; clear = 1'b0; detect_in = 1'b0; evt_ready = 1'b0;
        model_reset();

        // Table: idle up to ts=5, ten pulses at odd ts 5..23, then drain.
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0, 16'd0, 16'd0, 1'b0));
        for (int k = 0; k < 10; k++) begin
            logic [3:0]  lv;
            logic [15:0] dr;
            lv = (k < 8) ? 4'(k + 1) : 4'd8;
            dr = (k < 8) ? 16'd0 : 16'(k - 7);
            tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd5, lv, 16'(k + 1), dr, k >= 8));
            tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd5, lv, 16'(k + 1), dr, k >= 8));
        end
        for (int j = 0; j < 8; j++)
            tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, j < 7, (j < 7) ? 16'(7 + 2 * j) : 16'd0,
                             4'(7 - j), 16'd10, 16'd2, 1'b1));

        // Reset values while reset is held.
        #3;
        check_zero("reset");
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].en, tbl[i].clr, tbl[i].det, tbl[i].rdy);
            chk($sformatf("vec%0d_valid", i), {31'd0, evt_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("vec%0d_head", i),  {16'd0, evt_timestamp}, {16'd0, tbl[i].e_head});
            chk($sformatf("vec%0d_level", i), {28'd0, fifo_level}, {28'd0, tbl[i].e_level});
            chk($sformatf("vec%0d_cnt", i),   {16'd0, evt_count}, {16'd0, tbl[i].e_cnt});
            chk($sformatf("vec%0d_drop", i),  {16'd0, dropped_count}, {16'd0, tbl[i].e_drop});
            chk($sformatf("vec%0d_ov", i),    {31'd0, overflow}, {31'd0, tbl[i].e_ov});
        end

        // Full with simultaneous pop: fill at ts 25..32, then push+pop at ts 33.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("full_level", {28'd0, fifo_level}, 32'd8);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("fullpop_level", {28'd0, fifo_level}, 32'd8);
        chk("fullpop_drop", {16'd0, dropped_count}, 32'd2);
        chk("fullpop_head", {16'd0, evt_timestamp}, 32'd26);
        for (int j = 0; j < 8; j++) begin
            if (j == 7) chk("newest_last", {16'd0, evt_timestamp}, 32'd33);
            step(1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("drained_valid", {31'd0, evt_valid}, 32'd0);

        // Disabled: detection ignored, ts holds.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("disabled_level", {28'd0, fifo_level}, 32'd0);

        // Clear together with a detection, three entries queued (ts 34..36).
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("preclear_level", {28'd0, fifo_level}, 32'd3);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check_zero("clear");

        // Timestamp wrap on the 4-bit instance: events at ts 15 and 17 (=1).
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("wrap_first", {28'd0, evt_timestamp4}, 32'd15);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("wrap_second", {28'd0, evt_timestamp4}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset dropped between edges mid-stream.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_zero("async_rst");
        @(posedge clock);
        #1;
        check_zero("rst_held");
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("post_rst_valid", {31'd0, evt_valid}, 32'd1);
        chk("post_rst_ts", {16'd0, evt_timestamp}, 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("post_rst_next", {16'd0, evt_timestamp}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
